xbar_out_mux: RTL



---
 rtl/xbar_out_mux.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/xbar_out_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : xbar_out_mux
// | Description : Crossbar output-port frame multiplexer. Locks onto the
// |               arbiter-granted input for a whole frame and forwards its
// |               beats through a registered valid/ready output stage.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module xbar_out_mux #(
  parameter int DW   = 64,
  parameter int CNTW = 16
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic [4*DW-1:0] iData,
  input  logic [3:0]      iValid,
  input  logic [3:0]      iSop,
  input  logic [3:0]      iEop,
  output logic [3:0]      oReady,
  output logic [3:0]      oReq,
  input  logic [1:0]      iGrant,
  input  logic            iGrantValid,
  output logic [DW-1:0]   oData,
  output logic            oValid,
  output logic            oSop,
  output logic            oEop,
  output logic [1:0]      oPortId,
  input  logic            iOutReady,
  output logic [CNTW-1:0] oFrameCnt,
  output logic [CNTW-1:0] oErrCnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_sel;
  logic [1:0]      w_sel_nxt;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic            r_sop;
  logic            r_eop;
  logic [1:0]      r_port;
  logic [CNTW-1:0] r_frame_cnt;
  logic [CNTW-1:0] r_err_cnt;

  logic            w_can_load;
  logic            w_accept;
  logic            w_frame_inc;
  logic            w_err_inc;
  logic [3:0]      w_req;
  logic [3:0]      w_ready;
  logic [3:0]      w_sel_oh;
  logic [DW-1:0]   w_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = iData[gi*DW +: DW];
  end

  assign w_can_load = !r_valid || iOutReady;
  assign w_sel_oh   = 4'b0001 << r_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_req       = iValid;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_frame_inc = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iGrantValid && iValid[iGrant]) begin
          if (iSop[iGrant]) begin
            w_sel_nxt   = iGrant;
            w_state_nxt = S_XFER;
          end else begin
            // A granted input that is not at a frame start is out of sync: discard one beat.
            w_ready[iGrant] = 1'b1;
            w_err_inc       = 1'b1;
          end
        end
      end
      S_XFER: begin
        w_req    = iValid | w_sel_oh;
        w_ready  = w_can_load ? w_sel_oh : 4'b0000;
        w_accept = iValid[r_sel] && w_can_load;
        if (w_accept && iEop[r_sel]) begin
          w_frame_inc = 1'b1;
          w_state_nxt = S_REL;
        end
      end
      S_REL: begin
        w_req       = iValid & ~w_sel_oh;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_port      <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (w_can_load) begin
        r_valid <= w_accept;
        if (w_accept) begin
          r_data <= w_lane[r_sel];
          r_sop  <= iSop[r_sel];
          r_eop  <= iEop[r_sel];
          r_port <= r_sel;
        end
      end
      if (w_frame_inc && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_err_inc && (r_err_cnt != '1))     r_err_cnt   <= r_err_cnt + 1'b1;
    end
  end

  // Request/ready are combinational from iValid, so force them low while reset is held.
  assign oReq      = iRst_n ? w_req   : 4'b0000;
  assign oReady    = iRst_n ? w_ready : 4'b0000;
  assign oData     = r_data;
  assign oValid    = r_valid;
  assign oSop      = r_sop;
  assign oEop      = r_eop;
  assign oPortId   = r_port;
  assign oFrameCnt = r_frame_cnt;
  assign oErrCnt   = r_err_cnt;

endmodule
`default_nettype wire
